// File: rtl/alu_result_stage.sv
// ALU result stage: a one-entry valid/ready output register that captures ALU results,
// maintains the architectural HI/LO pair, merges status flags per operation class and counts accepts.
module alu_result_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  FS,
  input  logic [31:0] Y_HI,
  input  logic [31:0] Y_LO,
  input  logic        C,
  input  logic        V,
  input  logic        N,
  input  logic        Z,
  input  logic [1:0]  mf_sel,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] alu_out,
  output logic [3:0]  flags,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [15:0] op_count
);

  localparam logic [4:0] FS_MUL = 5'h1E;
  localparam logic [4:0] FS_DIV = 5'h1F;
  localparam logic [4:0] FS_SRL = 5'h0C;
  localparam logic [4:0] FS_SRA = 5'h0D;
  localparam logic [4:0] FS_SLL = 5'h0E;

  localparam logic [1:0] MF_HI = 2'b01;
  localparam logic [1:0] MF_LO = 2'b10;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  typedef enum logic [2:0] {
    OP_ALU,
    OP_MULDIV,
    OP_SHIFT,
    OP_MOVE_HI,
    OP_MOVE_LO
  } op_class_t;

  typedef struct packed {
    logic c;
    logic v;
    logic n;
    logic z;
  } flags_t;

  state_t    state, next_state;
  op_class_t op_class;
  logic      accept;
  logic      hi_lo_we;

  logic [31:0] alu_q, hi_q, lo_q, nxt_alu;
  flags_t      flag_q, nxt_flags;
  logic [15:0] cnt_q;

  // ---------------------------------------------------------------------------
  // Handshake FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= EMPTY;
    // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
    else       state <= next_state;
  end

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    next_state = state;
    in_ready   = (state == EMPTY) | out_ready;
    accept     = in_valid & in_ready;
    unique case (state)
      EMPTY:   if (accept) next_state = FULL;
      FULL:    if (out_ready && !accept) next_state = EMPTY;
      default: next_state = EMPTY;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Operation classification; MUL/DIV ignores mf_sel, moves take priority over shifts.
  // ---------------------------------------------------------------------------
  always_comb begin
    op_class = OP_ALU;
    if (FS == FS_MUL || FS == FS_DIV)                    op_class = OP_MULDIV;
    else if (mf_sel == MF_HI)                            op_class = OP_MOVE_HI;
    else if (mf_sel == MF_LO)                            op_class = OP_MOVE_LO;
    else if (FS == FS_SLL || FS == FS_SRL || FS == FS_SRA) op_class = OP_SHIFT;
  end

  // Flags that the ALU leaves undefined for an op class are carried over from the previous result.
  always_comb begin
    nxt_alu   = Y_LO;
    nxt_flags = flag_q;
    hi_lo_we  = 1'b0;
    unique case (op_class)
      OP_MULDIV: begin
        nxt_flags.n = N;
        nxt_flags.z = Z;
        hi_lo_we    = 1'b1;
      end
      OP_SHIFT: begin
        nxt_flags.c = C;
        nxt_flags.z = Z;
      end
      OP_MOVE_HI: nxt_alu = hi_q;
      OP_MOVE_LO: nxt_alu = lo_q;
      default:    nxt_flags = '{c: C, v: V, n: N, z: Z};
    endcase
  end

  // ---------------------------------------------------------------------------
  // Result, HI/LO and counter registers; everything changes only on an accept.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_q  <= '0;
      flag_q <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      cnt_q  <= '0;
    end else if (accept) begin
      alu_q  <= nxt_alu;
      flag_q <= nxt_flags;
      cnt_q  <= cnt_q + 16'd1;
      if (hi_lo_we) begin
        hi_q <= Y_HI;
        lo_q <= Y_LO;
      end
    end
  end

  assign out_valid = (state == FULL);
  assign alu_out   = alu_q;
  assign flags     = flag_q;
  assign HI        = hi_q;
  assign LO        = lo_q;
  assign op_count  = cnt_q;

endmodule

// File: tb/tb_alu_result_stage.sv
// Scoreboard bench for alu_result_stage: directed vectors push expected results,
// a negedge monitor pops and compares whenever the DUT hands off a result.
module tb_alu_result_stage;

  logic        clk, reset;
  logic        in_valid, in_ready;
  logic [4:0]  FS;
  logic [31:0] Y_HI, Y_LO;
  logic        C, V, N, Z;
  logic [1:0]  mf_sel;
  logic        out_valid, out_ready;
  logic [31:0] alu_out, HI, LO;
  logic [3:0]  flags;
  logic [15:0] op_count;

  alu_result_stage dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .FS(FS), .Y_HI(Y_HI), .Y_LO(Y_LO),
    .C(C), .V(V), .N(N), .Z(Z),
    .mf_sel(mf_sel),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_out(alu_out), .flags(flags),
    .HI(HI), .LO(LO), .op_count(op_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [31:0] alu;
    logic [3:0]  flg;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [15:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference model state
  logic [31:0] m_hi, m_lo;
  logic [3:0]  m_flags;
  logic [15:0] m_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_hi = '0; m_lo = '0; m_flags = '0; m_cnt = '0;
  endtask

  // Drive one transaction, wait (bounded) for acceptance, update the model and push the expectation.
  task automatic issue(input logic [4:0] fs, input logic [31:0] yhi, input logic [31:0] ylo,
                       input logic c, input logic v, input logic n, input logic z,
                       input logic [1:0] mf);
    exp_t e;
    int   waited = 0;
    FS = fs; Y_HI = yhi; Y_LO = ylo; C = c; V = v; N = n; Z = z; mf_sel = mf;
    in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      waited++;
      if (waited >= 50) begin
        check("accept_timeout", 32'(in_ready), 32'd1);
        in_valid = 1'b0;
        return;
      end
    end
    e.alu = ylo;
    if (fs == 5'h1E || fs == 5'h1F) begin
      m_flags = {m_flags[3], m_flags[2], n, z};
      m_hi = yhi; m_lo = ylo;
    end else if (mf == 2'b01) begin
      e.alu = m_hi;
    end else if (mf == 2'b10) begin
      e.alu = m_lo;
    end else if (fs == 5'h0C || fs == 5'h0D || fs == 5'h0E) begin
      m_flags = {c, m_flags[2], m_flags[1], z};
    end else begin
      m_flags = {c, v, n, z};
    end
    m_cnt = m_cnt + 16'd1;
    e.flg = m_flags; e.hi = m_hi; e.lo = m_lo; e.cnt = m_cnt;
    sb.push_back(e);
    @(posedge clk);
    #2;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int waited = 0;
    while (sb.size() != 0 && waited < 200) begin
      @(posedge clk);
      waited++;
    end
    if (sb.size() != 0) check("drain_timeout", 32'(sb.size()), 32'd0);
    #2;
  endtask

  // Monitor: a handoff happens on the edge following a negedge where out_valid & out_ready.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_output", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("alu_out",  alu_out,          e.alu);
        check("flags",    32'(flags),       32'(e.flg));
        check("HI",       HI,               e.hi);
        check("LO",       LO,               e.lo);
        check("op_count", 32'(op_count),    32'(e.cnt));
      end
    end
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    FS = '0; Y_HI = '0; Y_LO = '0; C = 0; V = 0; N = 0; Z = 0; mf_sel = '0;
    model_reset();

    // Reset state
    @(posedge clk); #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_alu_out",   alu_out,        32'd0);
    check("rst_flags",     32'(flags),     32'd0);
    check("rst_HI",        HI,             32'd0);
    check("rst_op_count",  32'(op_count),  32'd0);
    @(posedge clk); #2;
    reset = 1'b0;

    // Back-to-back directed vectors
    issue(5'h00, 32'h0,       32'h0000_1234, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00); // flags 1000
    issue(5'h1E, 32'h1,       32'h8000_0000, 1'bx, 1'bx, 1'b0, 1'b0, 2'b00); // MUL -> 1000
    issue(5'h02, 32'h5555,    32'hDEAD_BEEF, 1'b1, 1'b1, 1'b1, 1'b1, 2'b01); // MFHI -> 1
    issue(5'h02, 32'h5555,    32'hDEAD_BEEF, 1'b1, 1'b1, 1'b1, 1'b1, 2'b10); // MFLO -> 8000_0000
    issue(5'h05, 32'h0,       32'hAAAA_5555, 1'b0, 1'b1, 1'b1, 1'b0, 2'b11); // flags 0110
    issue(5'h0E, 32'h0,       32'h0000_0000, 1'b1, 1'bx, 1'bx, 1'b1, 2'b00); // SLL -> 1111
    issue(5'h1F, 32'h7,       32'h3,         1'bx, 1'bx, 1'b1, 1'b0, 2'b00); // DIV -> 1110
    issue(5'h0D, 32'h0,       32'hFFFF_FFF0, 1'b0, 1'bx, 1'bx, 1'b0, 2'b00); // SRA -> 0110
    drain();

    // Stall: FULL with out_ready low, new input waiting
    out_ready = 1'b0;
    issue(5'h00, 32'h0, 32'h1111_1111, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00);
    FS = 5'h00; Y_HI = 32'h9; Y_LO = 32'h2222_2222; C = 0; V = 0; N = 1; Z = 0; mf_sel = 2'b00;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_in_ready",  32'(in_ready),  32'd0);
      check("stall_out_valid", 32'(out_valid), 32'd1);
      check("stall_alu_out",   alu_out,        32'h1111_1111);
      check("stall_flags",     32'(flags),     32'h1);
      check("stall_HI",        HI,             32'h7);
      check("stall_LO",        LO,             32'h3);
      check("stall_op_count",  32'(op_count),  32'd9);
    end
    @(posedge clk); #2;
    out_ready = 1'b1;
    issue(5'h00, 32'h9, 32'h2222_2222, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00);
    drain();

    // Reset mid-transfer discards the held result
    out_ready = 1'b0;
    issue(5'h00, 32'h0, 32'h3333_3333, 1'b1, 1'b1, 1'b1, 1'b1, 2'b00);
    #1 reset = 1'b1;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready",  32'(in_ready),  32'd1);
    check("midrst_alu_out",   alu_out,        32'd0);
    check("midrst_flags",     32'(flags),     32'd0);
    check("midrst_HI",        HI,             32'd0);
    check("midrst_LO",        LO,             32'd0);
    check("midrst_op_count",  32'(op_count),  32'd0);
    sb.delete();
    model_reset();
    @(posedge clk); #2;
    reset = 1'b0;
    out_ready = 1'b1;
    issue(5'h02, 32'h0, 32'h4444_4444, 1'b1, 1'b1, 1'b1, 1'b1, 2'b01); // MFHI after reset -> 0
    drain();

    // Counter wrap: accept until op_count reaches FFFF, then one more
    while (m_cnt != 16'hFFFF) issue(5'h00, 32'h0, {16'h0, m_cnt}, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
    issue(5'h00, 32'h0, 32'h5A5A_5A5A, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00);
    drain();
    check("wrap_op_count", 32'(op_count), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_result_stage.md
ALU_RESULT_STAGE -- requirements
Module: alu_result_stage

Interface
REQ-001 clk  in  1  single system clock; all state updates on rising edge.
REQ-002 reset  in  1  asynchronous, active-high reset.
REQ-003 in_valid  in  1  ALU result presented on Y_HI/Y_LO/FS/flags this cycle.
REQ-004 in_ready  out  1  stage can accept a result this cycle.
REQ-005 FS  in  5  function select that produced the result (MUL=5'h1E, DIV=5'h1F, SRL=5'h0C, SRA=5'h0D, SLL=5'h0E, other=MIPS ops).
REQ-006 Y_HI, Y_LO  in  32 each  ALU result words.
REQ-007 C, V, N, Z  in  1 each  ALU status flags; may be X for MUL/DIV (C,V) and shifts (N,V).
REQ-008 mf_sel  in  2  result source: 00 ALU Y_LO, 01 HI register, 10 LO register, 11 reserved (treated as 00).
REQ-009 out_valid  out  1  alu_out/flags hold a result not yet consumed.
REQ-010 out_ready  in  1  downstream consumes result this cycle when out_valid=1.
REQ-011 alu_out  out  32  registered result word.
REQ-012 flags  out  4  registered {C,V,N,Z}.
REQ-013 HI, LO  out  32 each  architectural HI/LO registers.
REQ-014 op_count  out  16  count of accepted results.

Function
REQ-015 Two-state FSM, EMPTY (out_valid=0) and FULL (out_valid=1), shall govern the output register.
REQ-016 in_ready shall equal (state==EMPTY) | out_ready, combinationally.
REQ-017 Accept shall occur on a rising edge with in_valid & in_ready; no state changes when in_valid=0 or in_ready=0.
REQ-018 EMPTY + accept -> FULL; FULL + out_ready & !accept -> EMPTY; FULL + out_ready & accept -> FULL with new data (back-to-back, zero bubble); FULL + !out_ready -> hold all outputs stable.
REQ-019 Latency: accepted result appears on alu_out/flags with out_valid=1 one cycle after accept.
REQ-020 Accept with FS=MUL or DIV: HI<=Y_HI, LO<=Y_LO, alu_out<=Y_LO, flags N,Z<=inputs, C,V<=previous flags C,V (never X), mf_sel ignored.
REQ-021 Accept with FS=SLL/SRL/SRA: HI/LO unchanged, alu_out<=Y_LO, C,Z<=inputs, N,V<=previous flags N,V.
REQ-022 Accept with any other FS and mf_sel=00/11: HI/LO unchanged, alu_out<=Y_LO, all four flags<=inputs.
REQ-023 Accept with mf_sel=01/10 and FS not MUL/DIV: alu_out<=current HI/LO register value (pre-edge), flags unchanged, Y inputs ignored.
REQ-024 HI/LO shall update only on an accepted MUL/DIV, including while FULL and stalled only if in_ready=1 (i.e. never while stalled).
REQ-025 op_count shall increment by 1 on each accept, wrap 16'hFFFF->16'h0000, never saturate.
REQ-026 No X on any output after reset, regardless of X on C/V/N inputs per REQ-020/021.

Reset
REQ-027 reset=1 shall immediately (asynchronously) force state=EMPTY, out_valid=0, alu_out=0, flags=4'b0000, HI=0, LO=0, op_count=0.
REQ-028 reset asserted mid-transfer shall discard the held result; first accept after release behaves as from EMPTY.
REQ-029 in_ready shall be 1 while reset is asserted-and-released EMPTY, but no accept occurs while reset=1.

Verification
REQ-030 Reset: assert reset between edges -> all outputs 0 immediately, out_valid=0, in_ready=1.
REQ-031 MUL: FS=1E, Y_HI=32'h0000_0001, Y_LO=32'h8000_0000, N=0,Z=0, C=V=X, prior flags 4'b1000 -> next cycle HI=1, LO=32'h8000_0000, alu_out=32'h8000_0000, flags=4'b1000.
REQ-032 MFHI then MFLO: after REQ-031, mf_sel=01 then 10, FS=5'h02 -> alu_out 32'h0000_0001 then 32'h8000_0000, flags unchanged, HI/LO unchanged.
REQ-033 Stall: FULL with out_ready=0 for 3 cycles, in_valid=1 with new Y_LO -> in_ready=0, alu_out/flags/HI/LO/op_count stable; out_ready=1 -> new result loaded next cycle, op_count +1.
REQ-034 Shift flags: FS=0E, Y_LO=0, C=1, Z=1, N=V=X, prior flags 4'b0110 -> flags=4'b1111 (C=1,V=1 held,N=1 held,Z=1).
REQ-035 Wrap: preload op_count to 16'hFFFF via 65535 accepts, one more accept -> op_count=16'h0000.
